ex_mem_pipe_reg: RTL

Parametrised EX→MEM pipeline register with valid/ready handshake, synchronous flush and an optional one-entry skid buffer. It sits between the execute stage and the data-memory stage of the pipelined core.
- Latches the ALU result, store data, destination register and control bits.
- Lets MEM back-pressure EX without dropping in-flight instructions.
- Lets hazard control squash the stage.
- Never presents a write-enable on an invalid slot.

---
 rtl/ex_mem_pkg.sv | 27 ++
 rtl/ex_mem_pipe_reg_skid_buf.sv | 88 ++++++++
 rtl/ex_mem_pipe_reg.sv | 78 +++++++
 3 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM pipeline register: payload layout and the
// occupancy states of the valid/ready storage.
package ex_mem_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic              mem_write_en;
    logic              mem_to_reg;
    logic              reg_write;
    logic              branch;
    logic              zero;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] read_data_2;
    logic [REG_W-1:0]  rd_num;
  } ex_mem_payload_t;

  localparam int PAYLOAD_W = $bits(ex_mem_payload_t);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/ex_mem_pipe_reg_skid_buf.sv
// Generic valid/ready storage with an optional second (skid) entry.
//
//   state | meaning
//   EMPTY | nothing held, out_valid=0
//   ONE   | head entry in main_q
//   TWO   | head in main_q, next entry waiting in skid_q, in_ready=0
//
// With SKID=0 the TWO state is unreachable: when full, in_ready follows
// out_ready, so an accept while full always coincides with a pop.
module skid_buf #(
  parameter int W    = 8,
  parameter int SKID = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  import ex_mem_pkg::*;

  skid_state_t  state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_ready_q;
  logic         push;
  logic         pop;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_reg_ready
      assign in_ready = in_ready_q;
    end else begin : g_comb_ready
      // in_ready_q stays 1 here because TWO is never entered.
      assign in_ready = (!out_valid | out_ready) & in_ready_q;
    end
  endgenerate

  // Occupancy FSM; flush/reset empty both entries and zero the payload.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state      <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_q <= in_data;
          end else if (push) begin
            skid_q     <= in_data;
            state      <= TWO;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_q     <= skid_q;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register: packs the execute-stage bundle into a payload,
// holds it in the skid storage and gates the write/branch strobes with valid.
module ex_mem_pipe_reg #(
  parameter int DATA_W = ex_mem_pkg::DATA_W,
  parameter int REG_W  = ex_mem_pkg::REG_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_write_en,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic              branch,
  input  logic              zero,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic [REG_W-1:0]  rd_num,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mem_write_en_out,
  output logic              mem_to_reg_out,
  output logic              reg_write_out,
  output logic              branch_out,
  output logic              zero_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] read_data_2_out,
  output logic [REG_W-1:0]  rd_num_out,
  output logic              fwd_valid
);
  import ex_mem_pkg::*;

  ex_mem_payload_t in_pl;
  ex_mem_payload_t out_pl;

  assign in_pl = '{
    mem_write_en: mem_write_en,
    mem_to_reg:   mem_to_reg,
    reg_write:    reg_write,
    branch:       branch,
    zero:         zero,
    alu_result:   alu_result,
    read_data_2:  read_data_2,
    rd_num:       rd_num
  };

  skid_buf #(
    .W    (PAYLOAD_W),
    .SKID (SKID)
  ) u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  // Side-effecting strobes must never escape on an invalid slot, even though
  // the stale payload is still held underneath.
  assign mem_write_en_out = out_pl.mem_write_en & out_valid;
  assign reg_write_out    = out_pl.reg_write & out_valid;
  assign branch_out       = out_pl.branch & out_valid;

  assign mem_to_reg_out  = out_pl.mem_to_reg;
  assign zero_out        = out_pl.zero;
  assign alu_result_out  = out_pl.alu_result;
  assign read_data_2_out = out_pl.read_data_2;
  assign rd_num_out      = out_pl.rd_num;

  assign fwd_valid = reg_write_out;

endmodule
